// File: rtl/mem_arb_pkg.sv
// Shared types for the IM/DM to single-port memory arbiter.
// Optional tohost intercept is enabled with MEM_ARB_TOHOST_EN.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SERVE_IM,
    ARB_SERVE_DM
  } arb_state_e;

  typedef enum logic {
    ARB_PORT_IM,
    ARB_PORT_DM
  } arb_port_e;

  localparam logic [31:0] MEM_ARB_TOHOST_ADDR_DEFAULT = 32'h8000_1000;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising IM/DM accesses onto one sync memory.
// Define MEM_ARB_TOHOST_EN to intercept DM writes to TOHOST_ADDR.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR = MEM_ARB_TOHOST_ADDR_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        im_req_i,
  input  logic [31:0] im_addr_i,
  output logic [31:0] im_dout_o,
  output logic        im_busy_o,
  input  logic        dm_req_i,
  input  logic        dm_wen_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_din_i,
  output logic [31:0] dm_dout_o,
  output logic        dm_busy_o,
  output logic        mem_wen_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_din_o,
`ifdef MEM_ARB_TOHOST_EN
  output logic        tohost_int_o,
  output logic [31:0] tohost_data_o,
`endif
  input  logic [31:0] mem_dout_i
);

  arb_state_e  state_q;
  arb_state_e  state_d;
  arb_port_e   last_q;
  logic        gnt_im;
  logic        gnt_dm;
  logic        serve_im;
  logic        serve_dm;
  logic        wr_q;
  logic        tohost_hit;
  logic [31:0] im_q;
  logic [31:0] dm_q;

  // A completion only counts when not being reset in the same cycle.
  assign serve_im = (state_q == ARB_SERVE_IM) & ~rst_i;
  assign serve_dm = (state_q == ARB_SERVE_DM) & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      last_q  <= ARB_PORT_IM;
      wr_q    <= 1'b0;
      im_q    <= '0;
      dm_q    <= '0;
    end else begin
      state_q <= state_d;
      if (gnt_dm)
        last_q <= ARB_PORT_DM;
      else if (gnt_im)
        last_q <= ARB_PORT_IM;
      wr_q <= gnt_dm & dm_wen_i;
      if (serve_im)
        im_q <= mem_dout_i;
      if (serve_dm && !wr_q)
        dm_q <= mem_dout_i;
    end
  end

  always_comb begin
    gnt_im = 1'b0;
    gnt_dm = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        ARB_IDLE: begin
          if (im_req_i && dm_req_i) begin
            gnt_dm = (last_q == ARB_PORT_IM);
            gnt_im = ~gnt_dm;
          end else begin
            gnt_im = im_req_i;
            gnt_dm = dm_req_i;
          end
        end
        ARB_SERVE_IM: gnt_dm = dm_req_i;
        ARB_SERVE_DM: gnt_im = im_req_i;
        default: ;
      endcase
    end
    state_d = ARB_IDLE;
    unique case (1'b1)
      gnt_dm:  state_d = ARB_SERVE_DM;
      gnt_im:  state_d = ARB_SERVE_IM;
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    mem_addr_o = '0;
    mem_din_o  = '0;
    if (gnt_dm) begin
      mem_addr_o = dm_addr_i;
      mem_din_o  = dm_din_i;
    end else if (gnt_im) begin
      mem_addr_o = im_addr_i;
    end
    mem_wen_o = gnt_dm & dm_wen_i & ~tohost_hit;
    im_busy_o = im_req_i & ~serve_im;
    dm_busy_o = dm_req_i & ~serve_dm;
    im_dout_o = serve_im ? mem_dout_i : im_q;
    dm_dout_o = (serve_dm && !wr_q) ? mem_dout_i : dm_q;
  end

`ifdef MEM_ARB_TOHOST_EN
  logic        th_q;
  logic [31:0] th_data_q;

  assign tohost_hit = gnt_dm & dm_wen_i & (dm_addr_i == TOHOST_ADDR);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      th_q      <= 1'b0;
      th_data_q <= '0;
    end else begin
      th_q <= tohost_hit;
      if (tohost_hit)
        th_data_q <= dm_din_i;
    end
  end

  assign tohost_int_o  = th_q & serve_dm;
  assign tohost_data_o = tohost_int_o ? th_data_q : '0;
`else
  logic unused_tohost;

  assign tohost_hit    = 1'b0;
  assign unused_tohost = ^TOHOST_ADDR;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios then random IM/DM traffic.
// Define MEM_ARB_TOHOST_EN to also exercise the tohost intercept.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        im_req;
  logic [31:0] im_addr;
  logic [31:0] im_dout;
  logic        im_busy;
  logic        dm_req;
  logic        dm_wen;
  logic [31:0] dm_addr;
  logic [31:0] dm_din;
  logic [31:0] dm_dout;
  logic        dm_busy;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout = '0;
`ifdef MEM_ARB_TOHOST_EN
  logic        tohost_int;
  logic [31:0] tohost_data;
`endif

  mem_arbiter dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .im_req_i   (im_req),
    .im_addr_i  (im_addr),
    .im_dout_o  (im_dout),
    .im_busy_o  (im_busy),
    .dm_req_i   (dm_req),
    .dm_wen_i   (dm_wen),
    .dm_addr_i  (dm_addr),
    .dm_din_i   (dm_din),
    .dm_dout_o  (dm_dout),
    .dm_busy_o  (dm_busy),
    .mem_wen_o  (mem_wen),
    .mem_addr_o (mem_addr),
    .mem_din_o  (mem_din),
`ifdef MEM_ARB_TOHOST_EN
    .tohost_int_o  (tohost_int),
    .tohost_data_o (tohost_data),
`endif
    .mem_dout_i (mem_dout)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errs    = 0;
  int wen_cnt = 0;
  int n_wr    = 0;

  logic [31:0] imq[$];
  logic [31:0] dmq[$];
  logic [31:0] mem[logic [31:0]];
  logic [31:0] dm_ref[logic [31:0]];
  logic [31:0] dm_last = '0;

  function automatic logic [31:0] init_val(logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0000_0013 : (a ^ 32'h3C5A_96E1);
  endfunction

  function automatic logic [31:0] mem_rd(logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] ref_rd(logic [31:0] a);
    return dm_ref.exists(a) ? dm_ref[a] : init_val(a);
  endfunction

  // Single-port synchronous memory: read data valid the cycle after address.
  always @(posedge clk) begin
    mem_dout <= mem_rd(mem_addr);
    if (mem_wen)
      mem[mem_addr] = mem_din;
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every completion pops the port's next expected read data.
  always @(negedge clk) begin
    if (!rst && im_req && !im_busy) begin
      if (imq.size() == 0) begin
        vectors++;
        errs++;
        $display("FAIL im_extra: completion with dout %h, expected none", im_dout);
      end else begin
        chk("im_dout", im_dout, imq.pop_front());
      end
    end
    if (!rst && dm_req && !dm_busy) begin
      if (dmq.size() == 0) begin
        vectors++;
        errs++;
        $display("FAIL dm_extra: completion with dout %h, expected none", dm_dout);
      end else begin
        chk("dm_dout", dm_dout, dmq.pop_front());
      end
    end
    if (mem_wen)
      wen_cnt++;
  end

  task automatic push_dm_rd(logic [31:0] a);
    logic [31:0] v;
    v = ref_rd(a);
    dmq.push_back(v);
    dm_last = v;
  endtask

  task automatic push_dm_wr(logic [31:0] a, logic [31:0] d, bit to_mem);
    if (to_mem) begin
      dm_ref[a] = d;
      n_wr++;
    end
    dmq.push_back(dm_last);
  endtask

  task automatic wait_done(string nm, bit is_dm);
    int  cyc;
    bit  done;
    cyc  = 0;
    done = 0;
    while (!done && cyc <= 4) begin
      @(negedge clk);
      if (!(is_dm ? dm_busy : im_busy))
        done = 1;
      else
        cyc++;
      tick();
    end
    vectors++;
    if (!done || cyc > 2) begin
      errs++;
      $display("FAIL %s: busy for %0d cycles, allowed at most 2", nm, cyc);
    end
  endtask

  task automatic run_im(int n);
    logic [31:0] a;
    for (int k = 0; k < n; k++) begin
      im_req = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      a = 32'h8000_0000 + 32'(4 * $urandom_range(0, 15));
      im_addr = a;
      im_req  = 1'b1;
      imq.push_back(init_val(a));
      wait_done("im_latency", 1'b0);
    end
    im_req = 1'b0;
  endtask

  task automatic run_dm(int n);
    logic [31:0] a;
    logic [31:0] d;
    bit          wr;
    for (int k = 0; k < n; k++) begin
      dm_req = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      a  = 32'h8000_2000 + 32'(4 * $urandom_range(0, 7));
      d  = $urandom;
      wr = ($urandom_range(0, 2) == 0);
      dm_addr = a;
      dm_din  = d;
      dm_wen  = wr;
      dm_req  = 1'b1;
      if (wr)
        push_dm_wr(a, d, 1'b1);
      else
        push_dm_rd(a);
      wait_done("dm_latency", 1'b1);
    end
    dm_req = 1'b0;
    dm_wen = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int wen0;
    rst = 1'b1;
    im_req = 1'b0; im_addr = '0;
    dm_req = 1'b0; dm_wen = 1'b0; dm_addr = '0; dm_din = '0;
    tick();
    tick();
    im_req  = 1'b1;
    im_addr = 32'h8000_0000;
    @(negedge clk);
    chk("rst_im_busy", im_busy, 1);
    chk("rst_dm_busy", dm_busy, 0);
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_im_dout", im_dout, 0);
    chk("rst_dm_dout", dm_dout, 0);

    // IM-only read
    imq.push_back(init_val(32'h8000_0000));
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t1_mem_addr", mem_addr, 32'h8000_0000);
    chk("t1_busy_grant", im_busy, 1);
    tick();
    @(negedge clk);
    chk("t1_busy_done", im_busy, 0);
    chk("t1_dout", im_dout, 32'h0000_0013);
    tick();

    // Simultaneous requests: DM wins first
    dm_req = 1'b1; dm_wen = 1'b0; dm_addr = 32'h8000_2000;
    im_req = 1'b1; im_addr = 32'h8000_0004;
    push_dm_rd(32'h8000_2000);
    imq.push_back(init_val(32'h8000_0004));
    @(negedge clk);
    chk("t2_addr_n", mem_addr, 32'h8000_2000);
    chk("t2_dm_busy_n", dm_busy, 1);
    chk("t2_im_busy_n", im_busy, 1);
    tick();
    @(negedge clk);
    chk("t2_addr_n1", mem_addr, 32'h8000_0004);
    chk("t2_dm_busy_n1", dm_busy, 0);
    chk("t2_im_busy_n1", im_busy, 1);
    tick();
    dm_req = 1'b0;
    @(negedge clk);
    chk("t2_im_busy_n2", im_busy, 0);
    tick();
    im_req = 1'b0;
    tick();

    // Sustained contention alternates every cycle
    dm_req = 1'b1; dm_addr = 32'h8000_2008;
    im_req = 1'b1; im_addr = 32'h8000_0008;
    for (int i = 0; i < 5; i++) push_dm_rd(32'h8000_2008);
    for (int i = 0; i < 4; i++) imq.push_back(init_val(32'h8000_0008));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("t3_alt%0d", i), mem_addr,
          (i % 2 == 0) ? 32'h8000_2008 : 32'h8000_0008);
      tick();
    end
    dm_req = 1'b0;
    im_req = 1'b0;

    // DM write followed by IM read of the same word
    wen0 = wen_cnt;
    dm_req = 1'b1; dm_wen = 1'b1; dm_addr = 32'h8000_2004; dm_din = 32'hDEAD_BEEF;
    push_dm_wr(32'h8000_2004, 32'hDEAD_BEEF, 1'b1);
    @(negedge clk);
    chk("t4_wen", mem_wen, 1);
    chk("t4_addr", mem_addr, 32'h8000_2004);
    chk("t4_din", mem_din, 32'hDEAD_BEEF);
    tick();
    @(negedge clk);
    chk("t4_wen_off", mem_wen, 0);
    chk("t4_dm_busy", dm_busy, 0);
    tick();
    dm_req = 1'b0; dm_wen = 1'b0;
    im_req = 1'b1; im_addr = 32'h8000_2004;
    imq.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    chk("t4_im_busy", im_busy, 1);
    tick();
    @(negedge clk);
    chk("t4_im_done", im_busy, 0);
    tick();
    im_req = 1'b0;
    chk("t4_wen_pulses", 32'(wen_cnt - wen0), 1);

    // Reset during the DM completion cycle
    dm_req = 1'b1; dm_wen = 1'b0; dm_addr = 32'h8000_2010;
    push_dm_rd(32'h8000_2010);
    @(negedge clk);
    chk("t5_grant", mem_addr, 32'h8000_2010);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("t5_busy_rst", dm_busy, 1);
    tick();
    @(negedge clk);
    chk("t5_busy_rst2", dm_busy, 1);
    chk("t5_dout_rst", dm_dout, 0);
    chk("t5_addr_rst", mem_addr, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_regrant", mem_addr, 32'h8000_2010);
    chk("t5_busy_rel", dm_busy, 1);
    tick();
    @(negedge clk);
    chk("t5_done", dm_busy, 0);
    tick();
    dm_req = 1'b0;

`ifdef MEM_ARB_TOHOST_EN
    dm_req = 1'b1; dm_wen = 1'b1; dm_addr = 32'h8000_1000; dm_din = 32'h1;
    push_dm_wr(32'h8000_1000, 32'h1, 1'b0);
    @(negedge clk);
    chk("th_wen", mem_wen, 0);
    chk("th_int_grant", tohost_int, 0);
    tick();
    @(negedge clk);
    chk("th_int", tohost_int, 1);
    chk("th_data", tohost_data, 32'h1);
    tick();
    dm_req = 1'b0; dm_wen = 1'b0;
    @(negedge clk);
    chk("th_int_off", tohost_int, 0);
    chk("th_data_off", tohost_data, 0);
    tick();
`endif

    fork
      run_im(150);
      run_dm(150);
    join
    repeat (4) tick();
    chk("im_queue_left", imq.size(), 0);
    chk("dm_queue_left", dmq.size(), 0);
    chk("mem_write_count", wen_cnt, n_wr);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
